// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector load/store sequencer.
//   - vms_state_t : sequencer FSM states
//   - VmsLanes / VmsLaneW / VmsAddrW : default geometry
//   - laneSlice() : extract one lane from a packed vector at the default geometry
package vec_mem_pkg;

    localparam int unsigned VmsLanes    = 16;
    localparam int unsigned VmsLaneW    = 16;
    localparam int unsigned VmsAddrW    = 32;
    localparam int unsigned VmsLaneIdxW = $clog2(VmsLanes);

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoad,
        StTail,
        StDone
    } vms_state_t;

    function automatic logic [VmsLaneW-1:0] laneSlice(
        input logic [VmsLanes*VmsLaneW-1:0] vec,
        input logic [VmsLaneIdxW-1:0]       idx
    );
        return vec[idx*VmsLaneW +: VmsLaneW];
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Lane counter plus strided address accumulator.
//   clk, reset : clock, synchronous active-high reset
//   load       : restart at lane 0, address = base, capture stride
//   step       : advance one lane, address += stride (wraps modulo 2^ADDR_W)
//   base       : address of lane 0 (sampled on load)
//   stride     : per-lane address increment (sampled on load)
//   addr       : current address; holds when neither load nor step
//   lane       : current lane index
//   last       : current lane is LANES-1
module vec_addr_gen #(
    parameter int unsigned  LANES    = 16,
    parameter int unsigned  ADDR_W   = 32,
    localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W-1:0]   stride,
    output logic [ADDR_W-1:0]   addr,
    output logic [LaneIdxW-1:0] lane,
    output logic                last
);

    logic [ADDR_W-1:0]   addrQ;
    logic [ADDR_W-1:0]   strideQ;
    logic [LaneIdxW-1:0] laneQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            addrQ   <= '0;
            strideQ <= '0;
            laneQ   <= '0;
        end else if (load) begin
            addrQ   <= base;
            strideQ <= stride;
            laneQ   <= '0;
        end else if (step) begin
            // Accumulate rather than multiply; overflow wraps silently.
            addrQ <= addrQ + strideQ;
            laneQ <= laneQ + LaneIdxW'(1);
        end
    end

    assign addr = addrQ;
    assign lane = laneQ;
    assign last = (laneQ == LaneIdxW'(LANES - 1));

endmodule

// File: rtl/vec_mem_sequencer.sv
// Multi-cycle vector load/store engine for the M stage. Moves one vector register to/from a
// lane-wide data memory, one lane per cycle, with programmable stride.
//   clk, reset : clock, synchronous active-high reset
//   start      : request (accepted only in idle); store selects store (1) / load (0)
//   base_addr  : lane 0 address; stride : per-lane word increment
//   vdata_in   : store source vector; lane i = bits [i*LANE_W +: LANE_W]
//   mem_rdata  : memory read data, valid the cycle after a read strobe
//   mem_en, mem_we, mem_addr, mem_wdata : lane-wide memory port
//   vdata_out  : assembled load result, held until the next load overwrites it
//   stall      : freeze upstream pipeline registers
//   busy       : not idle; done : one-cycle completion pulse
module vec_mem_sequencer
    import vec_mem_pkg::*;
#(
    parameter int unsigned LANES  = VmsLanes,
    parameter int unsigned LANE_W = VmsLaneW,
    parameter int unsigned ADDR_W = VmsAddrW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [LANES*LANE_W-1:0] vdata_in,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    output logic [LANES*LANE_W-1:0] vdata_out,
    output logic                    stall,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1;

    vms_state_t              stateQ, stateD;
    logic [LANES*LANE_W-1:0] vdataQ;
    logic [LANES*LANE_W-1:0] vdataOutQ;
    logic                    rdValidQ;
    logic [LaneIdxW-1:0]     rdLaneQ;
    logic                    accept;
    logic                    inXfer;
    logic                    agStep;
    logic                    lastLane;
    logic [LaneIdxW-1:0]     lane;

    assign accept = (stateQ == StIdle) && start;
    assign inXfer = (stateQ == StStore) || (stateQ == StLoad);
    // Stop stepping on the last lane so mem_addr holds the final address afterwards.
    assign agStep = inXfer && !lastLane;

    vec_addr_gen #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) uAddrGen (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (agStep),
        .base   (base_addr),
        .stride (stride),
        .addr   (mem_addr),
        .lane   (lane),
        .last   (lastLane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Store source snapshot; later vdata_in changes are invisible to the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            vdataQ <= '0;
        end else if (accept) begin
            vdataQ <= vdata_in;
        end
    end

    // Read data returns one cycle after the strobe, so remember which lane was issued and
    // write it into the assembly register the following cycle (the last lane lands in TAIL).
    always_ff @(posedge clk) begin
        if (reset) begin
            rdValidQ  <= 1'b0;
            rdLaneQ   <= '0;
            vdataOutQ <= '0;
        end else begin
            rdValidQ <= (stateQ == StLoad);
            rdLaneQ  <= lane;
            if (rdValidQ) begin
                vdataOutQ[rdLaneQ*LANE_W +: LANE_W] <= mem_rdata;
            end
        end
    end

    assign vdata_out = vdataOutQ;

    always_comb begin
        stateD    = stateQ;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        stall     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (stateQ)
            StIdle: begin
                busy  = 1'b0;
                // Raw start term only; stall never feeds back into start.
                stall = start;
                if (start) begin
                    stateD = store ? StStore : StLoad;
                end
            end
            StStore: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = vdataQ[lane*LANE_W +: LANE_W];
                stall     = 1'b1;
                if (lastLane) begin
                    stateD = StDone;
                end
            end
            StLoad: begin
                mem_en = 1'b1;
                stall  = 1'b1;
                if (lastLane) begin
                    stateD = StTail;
                end
            end
            StTail: begin
                stall  = 1'b1;
                stateD = StDone;
            end
            StDone: begin
                // Stall drops here so the instruction leaves M with vdata_out complete.
                done   = 1'b1;
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;
    import vec_mem_pkg::*;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned ADDR_W = 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    store;
    logic [ADDR_W-1:0]       base_addr;
    logic [ADDR_W-1:0]       stride;
    logic [LANES*LANE_W-1:0] vdata_in;
    logic [LANE_W-1:0]       mem_rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [LANE_W-1:0]       mem_wdata;
    logic [LANES*LANE_W-1:0] vdata_out;
    logic                    stall;
    logic                    busy;
    logic                    done;

    int checks = 0;
    int errors = 0;
    logic [LANES*LANE_W-1:0] lastLoad;

    vec_mem_sequencer #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .store     (store),
        .base_addr (base_addr),
        .stride    (stride),
        .vdata_in  (vdata_in),
        .mem_rdata (mem_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .vdata_out (vdata_out),
        .stall     (stall),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory model: word[a] = a[15:0], one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && !mem_we) begin
            mem_rdata <= mem_addr[15:0];
        end
    end

    typedef struct {
        logic        isStore;
        logic [31:0] base;
        logic [31:0] strd;
        logic [15:0] vbase;       // store source lane i = vbase + i
        logic        disturb;     // perturb inputs and re-pulse start mid-transfer
        int          expDone;     // cycle of the done pulse
        logic [15:0] expLane0;    // store: first write data; load: vdata_out lane 0
        logic [15:0] expLane15;   // store: last write data;  load: vdata_out lane 15
        logic [31:0] expLastAddr; // address in cycle 16
    } xfer_t;

    xfer_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the caller's current cycle (idle); returns in the idle cycle after done.
    task automatic runXfer(input xfer_t r);
        logic [LANES*LANE_W-1:0] vd;
        logic [LANES*LANE_W-1:0] expVec;
        logic [31:0]             ea;
        logic [15:0]             ew;
        logic                    memOn;
        for (int i = 0; i < int'(LANES); i++) begin
            vd[i*LANE_W +: LANE_W]     = r.vbase + 16'(i);
            expVec[i*LANE_W +: LANE_W] = 16'(r.base + 32'(i) * r.strd);
        end
        start     = 1'b1;
        store     = r.isStore;
        base_addr = r.base;
        stride    = r.strd;
        vdata_in  = vd;
        #1;
        chk("stall_on_accept", 64'(stall), 64'(1));
        for (int c = 1; c <= r.expDone; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            memOn = (c <= int'(LANES));
            ea = memOn ? r.base + 32'(c - 1) * r.strd : r.base + 32'(LANES - 1) * r.strd;
            ew = (r.isStore && memOn) ? r.vbase + 16'(c - 1) : 16'h0;
            chk("mem_en", 64'(mem_en), 64'(memOn));
            chk("mem_we", 64'(mem_we), 64'(r.isStore && memOn));
            chk("mem_addr", 64'(mem_addr), 64'(ea));
            chk("mem_wdata", 64'(mem_wdata), 64'(ew));
            chk("stall", 64'(stall), 64'(c < r.expDone));
            chk("busy", 64'(busy), 64'(1));
            chk("done", 64'(done), 64'(c == r.expDone));
            if (c == 1 && r.isStore) chk("first_wdata", 64'(mem_wdata), 64'(r.expLane0));
            if (c == int'(LANES)) begin
                chk("last_addr", 64'(mem_addr), 64'(r.expLastAddr));
                if (r.isStore) chk("last_wdata", 64'(mem_wdata), 64'(r.expLane15));
            end
            if (r.disturb && c == 3) begin
                start     = 1'b1;
                store     = 1'b0;
                base_addr = 32'h0000_0999;
                vdata_in  = '1;
            end
            if (r.disturb && c == 4) start = 1'b0;
            if (c == r.expDone) begin
                if (r.isStore) begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        chk("vdata_hold", 64'(laneSlice(vdata_out, 4'(i))),
                            64'(lastLoad[i*LANE_W +: LANE_W]));
                    end
                end else begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        chk("load_lane", 64'(laneSlice(vdata_out, 4'(i))),
                            64'(expVec[i*LANE_W +: LANE_W]));
                    end
                    chk("load_lane0", 64'(laneSlice(vdata_out, 4'd0)), 64'(r.expLane0));
                    chk("load_lane15", 64'(laneSlice(vdata_out, 4'd15)), 64'(r.expLane15));
                    lastLoad = expVec;
                end
            end
        end
        tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_stall", 64'(stall), 64'(0));
        chk("idle_mem_en", 64'(mem_en), 64'(0));
        chk("idle_wdata", 64'(mem_wdata), 64'(0));
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0100, 32'd1, 16'h1000, 1'b0, 17, 16'h1000, 16'h100F,
                   32'h0000_010F};
        tbl[1] = '{1'b0, 32'h0000_0200, 32'd2, 16'h0000, 1'b0, 18, 16'h0200, 16'h021E,
                   32'h0000_021E};
        tbl[2] = '{1'b1, 32'hFFFF_FFFE, 32'd1, 16'h2000, 1'b0, 17, 16'h2000, 16'h200F,
                   32'h0000_000D};
        tbl[3] = '{1'b0, 32'h0000_ABCD, 32'd0, 16'h0000, 1'b0, 18, 16'hABCD, 16'hABCD,
                   32'h0000_ABCD};
        tbl[4] = '{1'b0, 32'hFFFF_FFFE, 32'd1, 16'h0000, 1'b0, 18, 16'hFFFE, 16'h000D,
                   32'h0000_000D};
        tbl[5] = '{1'b1, 32'h0000_0300, 32'd1, 16'h5000, 1'b1, 17, 16'h5000, 16'h500F,
                   32'h0000_030F};
        tbl[6] = '{1'b1, 32'h0000_0400, 32'd0, 16'h7000, 1'b0, 17, 16'h7000, 16'h700F,
                   32'h0000_0400};

        reset     = 1'b1;
        start     = 1'b0;
        store     = 1'b0;
        base_addr = '0;
        stride    = '0;
        vdata_in  = '0;
        lastLoad  = '0;
        repeat (3) tick();
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_vdata_zero", 64'(vdata_out == '0), 64'(1));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        reset = 1'b0;

        // Records run back-to-back: each start is raised in the idle cycle after done.
        for (int t = 0; t < 7; t++) begin
            runXfer(tbl[t]);
        end

        // Reset in cycle 7 of a load aborts it.
        start     = 1'b1;
        store     = 1'b0;
        base_addr = 32'h0000_0200;
        stride    = 32'd2;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
        end
        chk("pre_rst_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_mem_en", 64'(mem_en), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_vdata_zero", 64'(vdata_out == '0), 64'(1));
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'(0));
            chk("abort_no_mem", 64'(mem_en), 64'(0));
        end
        chk("abort_vdata_still_zero", 64'(vdata_out == '0), 64'(1));
        lastLoad = '0;
        runXfer(tbl[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
